// File: rtl/i2c_slave_regport.sv
// I2C target at a fixed 7-bit address. It decodes START/STOP, the address,
// register-pointer and data bytes, and maps bus transfers onto a byte-wide
// register port. SDA uses the open-drain o/oen pad style.
module i2c_slave_regport #(
    parameter logic [6:0] SLAVE_ADDR = 7'h20,
    parameter int         REG_AW     = 8,
    parameter int         FILT       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oen,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, PTR, ACK_P, WDAT, ACK_W, RDAT, MACK, WAIT
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        scl_sync, sda_sync;
    logic              scl_f, sda_f, scl_d, sda_d;
    logic [CW-1:0]     scl_cnt, sda_cnt;
    logic [3:0]        bit_cnt, bit_cnt_nx;
    logic [7:0]        shreg, shreg_nx;
    logic [REG_AW-1:0] ptr, ptr_nx;
    logic              rw, rw_nx;
    logic              oen_nx, busy_nx, wr_nx, rd_nx;
    logic [REG_AW-1:0] addr_nx;
    logic [7:0]        wdata_nx;
    logic [7:0]        byte_in;
    logic              scl_rise, scl_fall, start_c, stop_c;

    // The pad is only ever pulled low; release/drive is done through sda_oen.
    assign sda_o = 1'b0;

    // Two-flop synchronisers on both pad inputs, preset to the idle bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    // SCL glitch filter: follow the input only after FILT agreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == CW'(FILT - 1)) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + CW'(1);
        end
    end

    // SDA glitch filter, same rule as SCL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == CW'(FILT - 1)) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + CW'(1);
        end
    end

    // Delayed filtered lines for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    // SCL must be high both before and after the SDA edge to count as a condition.
    assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;
    assign byte_in  = {shreg[6:0], sda_f};

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oen   <= 1'b1;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            ptr       <= ptr_nx;
            rw        <= rw_nx;
            sda_oen   <= oen_nx;
            busy      <= busy_nx;
            reg_addr  <= addr_nx;
            reg_wdata <= wdata_nx;
            reg_wr    <= wr_nx;
            reg_rd    <= rd_nx;
        end
    end

    // Next-state and output decode; START/STOP override every state.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        ptr_nx     = ptr;
        rw_nx      = rw;
        oen_nx     = sda_oen;
        busy_nx    = busy;
        addr_nx    = reg_addr;
        wdata_nx   = reg_wdata;
        wr_nx      = 1'b0;
        rd_nx      = 1'b0;

        // Read data arrives the clk after the request.
        if (reg_rd) shreg_nx = reg_rdata;
        // Auto-increment follows each write strobe by one clk.
        if (reg_wr) ptr_nx = ptr + REG_AW'(1);

        if (start_c) begin
            state_nx   = ADDR;
            bit_cnt_nx = '0;
            oen_nx     = 1'b1;
            busy_nx    = 1'b0;
        end else if (stop_c) begin
            state_nx = IDLE;
            oen_nx   = 1'b1;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nx   = byte_in;
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (shreg[6:0] == SLAVE_ADDR) begin
                                busy_nx = 1'b1;
                                rw_nx   = sda_f;
                            end else begin
                                state_nx = WAIT;
                            end
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx   = ACK_A;
                        oen_nx     = 1'b0;
                        bit_cnt_nx = '0;
                        if (rw) begin
                            rd_nx   = 1'b1;
                            addr_nx = ptr;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        if (rw) begin
                            // This fall both ends the ACK and launches the data MSB.
                            state_nx   = RDAT;
                            oen_nx     = shreg[7];
                            shreg_nx   = {shreg[6:0], 1'b1};
                            bit_cnt_nx = 4'd1;
                        end else begin
                            state_nx   = PTR;
                            oen_nx     = 1'b1;
                            bit_cnt_nx = '0;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nx   = byte_in;
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ptr_nx  = REG_AW'(byte_in);
                            addr_nx = REG_AW'(byte_in);
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx   = ACK_P;
                        oen_nx     = 1'b0;
                        bit_cnt_nx = '0;
                    end
                end
                ACK_P: begin
                    if (scl_fall) begin
                        state_nx = WDAT;
                        oen_nx   = 1'b1;
                    end
                end
                WDAT: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg_nx   = byte_in;
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx   = ACK_W;
                        oen_nx     = 1'b0;
                        wr_nx      = 1'b1;
                        addr_nx    = ptr;
                        wdata_nx   = shreg;
                        bit_cnt_nx = '0;
                    end
                end
                ACK_W: begin
                    if (scl_fall) begin
                        state_nx = WDAT;
                        oen_nx   = 1'b1;
                    end
                end
                RDAT: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nx   = MACK;
                            oen_nx     = 1'b1;
                            bit_cnt_nx = '0;
                        end else begin
                            oen_nx     = shreg[7];
                            shreg_nx   = {shreg[6:0], 1'b1};
                            bit_cnt_nx = bit_cnt + 4'd1;
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            ptr_nx     = ptr + REG_AW'(1);
                            addr_nx    = ptr + REG_AW'(1);
                            rd_nx      = 1'b1;
                            state_nx   = RDAT;
                            bit_cnt_nx = '0;
                        end else begin
                            state_nx = WAIT;
                            busy_nx  = 1'b0;
                        end
                    end
                end
                WAIT:    state_nx = WAIT;
                IDLE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
